sccb_cfg_ctrl: RTL and testbench

Camera configuration sequencer: walks a register table and issues one SCCB 3-phase write (device address, register address, data) per entry to the image sensor. It owns SIO_C timing through a quarter-period tick generator and drives SIO_D open-drain. It sits between the top-level bring-up logic (one `start` pulse after power-up) and the sensor pads, ahead of the capture and VGA pipeline.

---
 rtl/cam_cfg_pkg.sv | 8 +
 rtl/sccb_cfg_ctrl_if.sv | 12 +
 rtl/sccb_tick_gen.sv | 16 +
 rtl/sccb_cfg_ctrl.sv | 111 +++++++++++
 tb/tb_sccb_cfg_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/cam_cfg_pkg.sv
// cam_cfg_pkg: shared states and table markers for the camera config sequencer
package cam_cfg_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, START, BYTE, STOP, GAP, WAIT, DONE} cfg_state_e;
    localparam logic [15:0] CFG_END = 16'hFFFF;
    localparam logic [15:0] CFG_DELAY = 16'hFFF0;
    localparam int SCCB_BITS_PER_WRITE = 27;
    localparam int GAP_QUARTERS = 8;
endpackage

// File: rtl/sccb_cfg_ctrl_if.sv
// sccb_cfg_ctrl_if: bring-up handshake, table ROM port and SCCB pad signals
interface sccb_cfg_ctrl_if;
    logic start;
    logic [7:0] rom_addr;
    logic [15:0] rom_data;
    logic sio_c;
    logic sio_d_oe;
    logic busy;
    logic done;
    modport master(input start, rom_data, output rom_addr, sio_c, sio_d_oe, busy, done);
    modport slave(output start, rom_data, input rom_addr, sio_c, sio_d_oe, busy, done);
endinterface

// File: rtl/sccb_tick_gen.sv
// sccb_tick_gen: one-clk pulse every CLK_DIV cycles marking an SCL quarter-period
module sccb_tick_gen #(
    parameter int CLK_DIV = 125
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic qtick
);
    localparam int CW = $clog2(CLK_DIV);
    logic [CW-1:0] cnt;
    assign qtick = cnt == CW'(CLK_DIV - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else cnt <= (clear || qtick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/sccb_cfg_ctrl.sv
// sccb_cfg_ctrl: walks the config table, one SCCB 3-phase write per entry
module sccb_cfg_ctrl
    import cam_cfg_pkg::*;
#(
    parameter int CLK_DIV = 125,
    parameter logic [7:0] DEV_ADDR = 8'h42,
    parameter int DELAY_CYC = 500000
) (
    input logic clk,
    input logic rst,
    sccb_cfg_ctrl_if.master bus
);
    localparam int WW = $clog2(DELAY_CYC + 1);
    cfg_state_e state, state_n;
    logic [2:0] q, q_n;
    logic [3:0] pos, pos_n;
    logic [4:0] nb, nb_n;
    logic [23:0] sh, sh_n;
    logic [7:0] addr_n;
    logic [WW-1:0] wcnt, wcnt_n;
    logic scl_n, oe_n, qtick, adv;

    sccb_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .rst(rst), .clear(state == FETCH), .qtick(qtick));

    assign bus.busy = !(state inside {IDLE, DONE});
    assign bus.done = state == DONE;

    always_comb begin
        state_n = state;
        q_n = q;
        pos_n = pos;
        nb_n = nb;
        sh_n = sh;
        addr_n = bus.rom_addr;
        wcnt_n = wcnt;
        adv = 1'b0;
        case (state)
            IDLE, DONE: if (bus.start) begin
                state_n = FETCH;
                addr_n = '0;
            end
            FETCH: begin
                q_n = '0;
                pos_n = '0;
                nb_n = '0;
                wcnt_n = '0;
                sh_n = {DEV_ADDR, bus.rom_data};
                state_n = bus.rom_data == CFG_END ? DONE : bus.rom_data == CFG_DELAY ? WAIT : START;
            end
            START: if (qtick) begin
                q_n = q == 3'd1 ? 3'd0 : q + 3'd1;
                state_n = q == 3'd1 ? BYTE : START;
            end
            BYTE: if (qtick) begin
                q_n = {1'b0, q[1:0] + 2'd1};
                // bit 8 of each byte is the released ACK slot: no shift there
                if (q == 3'd3) begin
                    pos_n = pos == 4'd8 ? 4'd0 : pos + 4'd1;
                    sh_n = pos == 4'd8 ? sh : sh << 1;
                    nb_n = nb + 5'd1;
                    state_n = nb == 5'(SCCB_BITS_PER_WRITE - 1) ? STOP : BYTE;
                end
            end
            STOP: if (qtick) begin
                q_n = q == 3'd2 ? 3'd0 : q + 3'd1;
                state_n = q == 3'd2 ? GAP : STOP;
            end
            GAP: if (qtick) begin
                q_n = q + 3'd1;
                adv = q == 3'(GAP_QUARTERS - 1);
            end
            WAIT: begin
                wcnt_n = wcnt + 1'b1;
                adv = wcnt == WW'(DELAY_CYC - 1);
            end
            default: ;
        endcase
        // the last table slot ends the walk instead of wrapping to entry 0
        if (adv) begin
            state_n = bus.rom_addr == 8'hFF ? DONE : FETCH;
            addr_n = bus.rom_addr == 8'hFF ? bus.rom_addr : bus.rom_addr + 8'd1;
        end
        scl_n = state_n == BYTE ? q_n[1] : state_n == STOP ? q_n != 3'd0 : 1'b1;
        oe_n = state_n == START ? q_n == 3'd1 :
               state_n == BYTE ? (pos_n != 4'd8 && !sh_n[23]) :
               state_n == STOP ? q_n != 3'd2 : 1'b0;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            q <= '0;
            pos <= '0;
            nb <= '0;
            sh <= '0;
            wcnt <= '0;
            bus.rom_addr <= '0;
            bus.sio_c <= 1'b1;
            bus.sio_d_oe <= 1'b0;
        end else begin
            state <= state_n;
            q <= q_n;
            pos <= pos_n;
            nb <= nb_n;
            sh <= sh_n;
            wcnt <= wcnt_n;
            bus.rom_addr <= addr_n;
            bus.sio_c <= scl_n;
            bus.sio_d_oe <= oe_n;
        end
endmodule

// File: tb/tb_sccb_cfg_ctrl.sv
// tb_sccb_cfg_ctrl: random config tables, bus decoded into frames and compared to a table-walk model
module tb_sccb_cfg_ctrl;
    localparam int CD = 4;
    localparam int CD1 = 2;
    localparam int DLY = 100;

    logic clk = 1'b0;
    logic [1:0] rst = 2'b11;
    logic [1:0] st = 2'b00;
    logic [1:0] mc = 2'b00;
    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;

    logic [15:0] tbl [2][256];
    logic [26:0] exp_f [2][300];
    logic [26:0] got_f [2][300];
    int exp_n [2];
    int exp_lat [2];
    logic [7:0] exp_addr [2];
    int got_n [2];
    int nb [2];
    int stop_t [2];
    int gap_last [2];
    logic [27:0] sr [2];
    logic pscl [2];
    logic psda [2];
    logic have_stop [2];
    logic [7:0] ra [2];

    sccb_cfg_ctrl_if bus0();
    sccb_cfg_ctrl_if bus1();

    sccb_cfg_ctrl #(.CLK_DIV(CD), .DEV_ADDR(8'h42), .DELAY_CYC(DLY)) u_dut (.clk(clk), .rst(rst[0]), .bus(bus0));
    // second instance at the fastest legal SCL so the full 256-entry walk stays short
    sccb_cfg_ctrl #(.CLK_DIV(CD1), .DEV_ADDR(8'h42), .DELAY_CYC(DLY)) u_dut1 (.clk(clk), .rst(rst[1]), .bus(bus1));

    assign bus0.start = st[0];
    assign bus1.start = st[1];
    assign bus0.rom_data = tbl[0][bus0.rom_addr];
    assign bus1.rom_data = tbl[1][bus1.rom_addr];
    assign ra[0] = bus0.rom_addr;
    assign ra[1] = bus1.rom_addr;
    wire [1:0] scl = {bus1.sio_c, bus0.sio_c};
    wire [1:0] sda = ~{bus1.sio_d_oe, bus0.sio_d_oe};
    wire [1:0] dn = {bus1.done, bus0.done};
    wire [1:0] bz = {bus1.busy, bus0.busy};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // bus decoder: START/STOP from SDA edges with SCL high, data on SCL rise
    always @(negedge clk)
        for (int g = 0; g < 2; g++) begin
            if (mc[g]) begin
                nb[g] = 0;
                got_n[g] = 0;
                have_stop[g] = 1'b0;
                gap_last[g] = -1;
            end else if (scl[g] && pscl[g] && psda[g] && !sda[g]) begin
                nb[g] = 0;
                if (have_stop[g]) gap_last[g] = cyc - stop_t[g];
            end else if (scl[g] && pscl[g] && !psda[g] && sda[g]) begin
                if (nb[g] == 28 && got_n[g] < 300) begin
                    got_f[g][got_n[g]] = sr[g][27:1];
                    got_n[g]++;
                end
                stop_t[g] = cyc;
                have_stop[g] = 1'b1;
            end else if (scl[g] && !pscl[g]) begin
                sr[g] = {sr[g][26:0], sda[g]};
                nb[g]++;
            end
            pscl[g] = scl[g];
            psda[g] = sda[g];
        end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rnd_entry();
        logic [15:0] v;
        v = 16'($urandom);
        return v >= 16'hFFF0 ? v - 16'h0100 : v;
    endfunction

    // walk the table: expected frames, final rom_addr and start-to-done latency
    task automatic model(input int g);
        int lat;
        int cdv;
        logic [15:0] e;
        lat = 0;
        cdv = g == 0 ? CD : CD1;
        exp_n[g] = 0;
        exp_addr[g] = 8'hFF;
        for (int i = 0; i < 256; i++) begin
            e = tbl[g][i];
            lat += 1;
            if (e == 16'hFFFF) begin
                exp_addr[g] = 8'(i);
                break;
            end
            if (e == 16'hFFF0) lat += DLY;
            else begin
                exp_f[g][exp_n[g]] = {8'h42, 1'b1, e[15:8], 1'b1, e[7:0], 1'b1};
                exp_n[g]++;
                lat += (2 + 4 * 27 + 3 + 8) * cdv;
            end
        end
        exp_lat[g] = lat;
    endtask

    task automatic pulse(input int g, input bit clr, output int t);
        @(posedge clk);
        #1 mc[g] = clr;
        @(negedge clk);
        #1 mc[g] = 1'b0;
        st[g] = 1'b1;
        @(posedge clk);
        #1 t = cyc;
        st[g] = 1'b0;
    endtask

    task automatic walk(input int g, input int t0);
        int n;
        n = 0;
        while (!dn[g] && n < exp_lat[g] + 100) begin
            @(negedge clk);
            n++;
        end
        chk("done", 32'(dn[g]), 1);
        chk("latency", cyc - t0, exp_lat[g]);
        chk("busy_end", 32'(bz[g]), 0);
        chk("rom_addr_end", 32'(ra[g]), 32'(exp_addr[g]));
        chk("nwrites", got_n[g], exp_n[g]);
        for (int i = 0; i < exp_n[g] && i < got_n[g]; i++)
            chk($sformatf("frame%0d", i), 32'(got_f[g][i]), 32'(exp_f[g][i]));
    endtask

    initial begin
        int t0, t1, n;
        for (int i = 0; i < 256; i++) begin
            tbl[0][i] = 16'hFFFF;
            tbl[1][i] = 16'hFFFF;
        end
        repeat (3) @(negedge clk);
        chk("rst_sio_c", 32'(bus0.sio_c), 1);
        chk("rst_sio_d_oe", 32'(bus0.sio_d_oe), 0);
        chk("rst_busy", 32'(bus0.busy), 0);
        chk("rst_done", 32'(bus0.done), 0);
        chk("rst_rom_addr", 32'(bus0.rom_addr), 0);
        rst = 2'b00;
        fork
            begin
                for (int i = 0; i < 256; i++) tbl[1][i] = rnd_entry();
                model(1);
                pulse(1, 1'b1, t1);
                walk(1, t1);
            end
            begin
                tbl[0][0] = 16'h1280;
                tbl[0][1] = 16'hFFFF;
                model(0);
                pulse(0, 1'b1, t0);
                walk(0, t0);

                tbl[0][1] = 16'hFFF0;
                tbl[0][2] = 16'h1101;
                tbl[0][3] = 16'hFFFF;
                model(0);
                pulse(0, 1'b1, t0);
                walk(0, t0);
                chk("delay_gap", gap_last[0], CD + 8 * CD + 1 + DLY + 1 + CD);

                repeat (3) begin
                    n = $urandom_range(1, 5);
                    for (int i = 0; i < n; i++) tbl[0][i] = $urandom_range(0, 3) == 0 ? 16'hFFF0 : rnd_entry();
                    tbl[0][n] = 16'hFFFF;
                    model(0);
                    pulse(0, 1'b1, t0);
                    walk(0, t0);
                end

                for (int i = 0; i < 3; i++) tbl[0][i] = rnd_entry();
                tbl[0][3] = 16'hFFFF;
                model(0);
                pulse(0, 1'b1, t0);
                while (cyc < t0 + 121 * CD + 2 * CD + 8) @(negedge clk);
                chk("mid_rom_addr", 32'(ra[0]), 1);
                pulse(0, 1'b0, t1);
                chk("ign_busy", 32'(bz[0]), 1);
                chk("ign_rom_addr", 32'(ra[0]), 1);
                walk(0, t0);
                pulse(0, 1'b1, t0);
                chk("restart_done", 32'(dn[0]), 0);
                chk("restart_rom_addr", 32'(ra[0]), 0);
                chk("restart_busy", 32'(bz[0]), 1);
                walk(0, t0);

                tbl[0][0] = rnd_entry();
                tbl[0][1] = rnd_entry();
                tbl[0][2] = 16'hFFFF;
                model(0);
                pulse(0, 1'b1, t0);
                while (cyc < t0 + 1 + 2 * CD + 36 * CD + 8) @(negedge clk);
                n = 0;
                while (scl[0] && n < 8) begin
                    @(negedge clk);
                    n++;
                end
                #1 rst[0] = 1'b1;
                #1 chk("rstmid_sio_c", 32'(bus0.sio_c), 1);
                chk("rstmid_sio_d_oe", 32'(bus0.sio_d_oe), 0);
                chk("rstmid_busy", 32'(bus0.busy), 0);
                chk("rstmid_rom_addr", 32'(bus0.rom_addr), 0);
                @(negedge clk);
                rst[0] = 1'b0;
                pulse(0, 1'b1, t0);
                chk("rstmid_restart_addr", 32'(ra[0]), 0);
                walk(0, t0);
            end
        join
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
